// File: rtl/rfft_unloader.sv
// rfft_unloader: drains one 256-sample frame from the real-FFT core
// (4 lanes x 64 addresses) into a one-sample-per-beat valid/ready stream.
// Two four-sample slots used ping-pong keep the stream bubble-free when the
// sink never stalls. Reads are only issued into a slot that is already
// reserved, so a stalled sink can never cause data to be overwritten.

module rfft_unloader #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LANES  = 4,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_done,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd,
    input  logic [WIDTH-1:0]  i_dout0,
    input  logic [WIDTH-1:0]  i_dout1,
    input  logic [WIDTH-1:0]  i_dout2,
    input  logic [WIDTH-1:0]  i_dout3,
    output logic [WIDTH-1:0]  o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic              o_m_last,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overrun
);

    localparam int unsigned TOTAL  = LANES * DEPTH;
    localparam int unsigned CNT_W  = $clog2(TOTAL);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned RCNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(TOTAL - 1);
    localparam logic [LANE_W-1:0] LAST_LANE   = LANE_W'(LANES - 1);
    localparam logic [RCNT_W-1:0] READS_TOTAL = RCNT_W'(DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // Control state
    state_e              r_state;
    state_e              w_state_d;
    logic                r_done_q;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_overrun;

    // Read side: r_rd_cnt counts reads issued this frame (0..DEPTH)
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic [RCNT_W-1:0]   r_rd_cnt;
    logic                r_cap;      // core data is valid this cycle
    logic [1:0]          r_used;     // slots filled or with a read in flight

    // Slot buffer and stream side
    logic [WIDTH-1:0]    r_slot [2][LANES];
    logic [1:0]          r_full;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [LANE_W-1:0]   r_lane;
    logic [CNT_W-1:0]    r_out_cnt;  // frame index of the presented sample

    logic                w_start;
    logic                w_accept;
    logic                w_valid;
    logic                w_hs;
    logic                w_hs3;
    logic                w_last_hs;
    logic                w_issue;

    // Start detection, handshake decode, read-issue decision and FSM next state
    always_comb begin
        w_state_d = r_state;
        w_start   = i_done & ~r_done_q;
        w_valid   = r_full[r_rd_ptr];
        w_hs      = w_valid & i_m_ready;
        w_hs3     = w_hs & (r_lane == LAST_LANE);
        w_last_hs = w_hs & (r_out_cnt == LAST_SAMPLE);
        w_accept  = 1'b0;
        w_issue   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_accept  = 1'b1;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                // A slot emptied by this cycle's lane-3 handshake counts as free
                w_issue = (r_rd_cnt < READS_TOTAL) & ((r_used < 2'd2) | w_hs3);
                if (w_last_hs) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Status flags and edge-detect history
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_done_q     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done_q     <= i_done;
            r_busy       <= (w_state_d == StRun);
            r_frame_done <= w_last_hs;
            // Includes a start landing on the final-handshake cycle
            r_overrun    <= w_start & (r_state == StRun);
        end
    end

    // Core read sequencing and slot reservation count
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_rd_cnt <= '0;
            r_cap    <= 1'b0;
            r_used   <= '0;
        end else begin
            r_cap <= r_rd;
            if (w_accept) begin
                r_addr   <= '0;
                r_rd     <= 1'b1;
                r_rd_cnt <= RCNT_W'(1);
                r_used   <= 2'd1;
            end else begin
                r_rd <= w_issue;
                if (w_issue) begin
                    r_addr   <= r_rd_cnt[ADDR_W-1:0];
                    r_rd_cnt <= r_rd_cnt + RCNT_W'(1);
                end
                unique case ({w_issue, w_hs3})
                    2'b10:   r_used <= r_used + 2'd1;
                    2'b01:   r_used <= r_used - 2'd1;
                    default: r_used <= r_used;
                endcase
            end
        end
    end

    // Slot occupancy, ping-pong pointers and stream position
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_lane    <= '0;
            r_out_cnt <= '0;
        end else if (w_accept) begin
            r_full    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_lane    <= '0;
            r_out_cnt <= '0;
        end else begin
            // The capture target is never the slot being freed: it was reserved
            // while the presented slot was still full.
            if (r_cap) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_hs) begin
                r_lane    <= r_lane + LANE_W'(1);
                r_out_cnt <= r_out_cnt + CNT_W'(1);
                if (w_hs3) begin
                    r_full[r_rd_ptr] <= 1'b0;
                    r_rd_ptr         <= ~r_rd_ptr;
                end
            end
        end
    end

    // Capture the four core lanes into the slot being filled
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_slot[s][l] <= '0;
                end
            end
        end else if (r_cap) begin
            r_slot[r_wr_ptr][0] <= i_dout0;
            r_slot[r_wr_ptr][1] <= i_dout1;
            r_slot[r_wr_ptr][2] <= i_dout2;
            r_slot[r_wr_ptr][3] <= i_dout3;
        end
    end

    // Stream outputs come straight from registers, never from i_m_ready
    assign o_m_valid    = w_valid;
    assign o_m_data     = w_valid ? r_slot[r_rd_ptr][r_lane] : '0;
    assign o_m_last     = w_valid & (r_out_cnt == LAST_SAMPLE);
    assign o_addr       = r_addr;
    assign o_rd         = r_rd;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_rfft_unloader.sv
// Bench for rfft_unloader: a core model answering reads with 4*addr+lane,
// a frame-level stream model checked every cycle, and directed scenarios.

module tb_rfft_unloader;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 6;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              done    = 1'b0;
    logic              m_ready = 1'b1;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic [WIDTH-1:0]  dout0, dout1, dout2, dout3;
    logic [WIDTH-1:0]  m_data;
    logic              m_valid;
    logic              m_last;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: alternate, 2: manual

    // Frame-level model state
    bit m_busy, m_ov, m_fd, m_done_q;
    int exp_idx, exp_addr, rd_cnt, groups, since;
    bit prev_stall, prev_last;
    logic [WIDTH-1:0] prev_data;
    int cyc, t_first, t_last, fd_seen, ov_seen;

    rfft_unloader #(
        .WIDTH  (16),
        .LANES  (4),
        .DEPTH  (64),
        .ADDR_W (6)
    ) u_dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_done       (done),
        .o_addr       (addr),
        .o_rd         (rd),
        .i_dout0      (dout0),
        .i_dout1      (dout1),
        .i_dout2      (dout2),
        .i_dout3      (dout3),
        .o_m_data     (m_data),
        .o_m_valid    (m_valid),
        .i_m_ready    (m_ready),
        .o_m_last     (m_last),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Core model: data valid exactly one cycle after Rd, junk otherwise
    always @(posedge clk) begin
        if (rd) begin
            dout0 <= WIDTH'({addr, 2'b00}) + 16'd0;
            dout1 <= WIDTH'({addr, 2'b00}) + 16'd1;
            dout2 <= WIDTH'({addr, 2'b00}) + 16'd2;
            dout3 <= WIDTH'({addr, 2'b00}) + 16'd3;
        end else begin
            dout0 <= 16'hE0A0;
            dout1 <= 16'hE0A1;
            dout2 <= 16'hE0A2;
            dout3 <= 16'hE0A3;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode == 0) m_ready = 1'b1;
        else if (rdy_mode == 1) m_ready = ~m_ready;
    endtask

    task automatic wait_sample(input int v, input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            if (m_valid && m_data == WIDTH'(v)) found = 1'b1;
        end
        chk($sformatf("reach_sample_%0d", v), 32'(found), 32'd1);
    endtask

    task automatic wait_fd(input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            if (frame_done) found = 1'b1;
        end
        chk("reach_frame_done", 32'(found), 32'd1);
    endtask

    // Per-cycle comparison against the frame-level model
    task automatic monitor();
        bit hs, start, last_hs;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_ov = 0; m_fd = 0; m_done_q = 0;
                exp_idx = 0; exp_addr = 0; rd_cnt = 0; groups = 0;
                since = 1000; prev_stall = 0;
            end else begin
                cyc++;
                if (since < 1000) since++;
                chk("busy", 32'(busy), 32'(m_busy));
                chk("overrun", 32'(overrun), 32'(m_ov));
                chk("frame_done", 32'(frame_done), 32'(m_fd));
                if (overrun) ov_seen++;
                if (frame_done) fd_seen++;
                if (!m_busy) begin
                    chk("idle_quiet", 32'({m_valid, rd}), 32'd0);
                end else begin
                    if (m_valid) begin
                        chk("data", 32'(m_data), 32'(exp_idx));
                        chk("last", 32'(m_last), 32'(exp_idx == 255));
                    end else begin
                        chk("last_without_valid", 32'(m_last), 32'd0);
                    end
                    if (prev_stall)
                        chk("stall_stable", 32'({m_valid, m_last, m_data}),
                            32'({1'b1, prev_last, prev_data}));
                    if (rd) begin
                        chk("rd_addr", 32'(addr), 32'(exp_addr));
                        chk("rd_limit", 32'(rd_cnt < 64), 32'd1);
                        chk("rd_buffered", 32'((rd_cnt + 1 - groups) <= 2), 32'd1);
                    end
                    if (since == 1) chk("lat_first_rd", 32'({rd, addr}), 32'({1'b1, 6'd0}));
                    if (since == 2) chk("lat_no_valid", 32'(m_valid), 32'd0);
                    if (since == 3) chk("lat_valid", 32'({m_valid, m_data}), 32'({1'b1, 16'd0}));
                end
                hs         = m_valid & m_ready;
                start      = done & ~m_done_q;
                last_hs    = m_busy && hs && exp_idx == 255;
                prev_stall = m_valid & ~m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                if (rd) begin
                    rd_cnt++;
                    exp_addr++;
                end
                if (m_busy && hs) begin
                    if (exp_idx == 0) t_first = cyc;
                    if (exp_idx == 255) t_last = cyc;
                    if (exp_idx % 4 == 3) groups++;
                    exp_idx++;
                end
                if (last_hs) chk("rd_total", 32'(rd_cnt), 32'd64);
                m_ov = start & m_busy;
                m_fd = last_hs;
                if (last_hs) begin
                    m_busy = 0;
                end else if (start && !m_busy) begin
                    m_busy = 1; exp_idx = 0; exp_addr = 0; rd_cnt = 0; groups = 0;
                    since = 0; prev_stall = 0;
                end
                m_done_q = done;
            end
        end
    endtask

    initial begin
        int fd0, ov0, nrd;
        fork
            monitor();
        join_none

        repeat (3) step();
        chk("reset_outputs",
            32'({addr, rd, m_data, m_valid, m_last, busy, frame_done, overrun}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Continuous stream, no backpressure
        fd0  = fd_seen;
        done = 1'b1;
        wait_fd(400);
        step();
        chk("cont_span", 32'(t_last - t_first), 32'd255);
        chk("cont_addr_hold", 32'(addr), 32'd63);
        chk("cont_frames", 32'(fd_seen - fd0), 32'd1);
        done = 1'b0;
        repeat (2) step();

        // Alternating ready
        rdy_mode = 1;
        done     = 1'b1;
        wait_fd(800);
        chk("bp_span", 32'(t_last - t_first), 32'd510);
        rdy_mode = 0;
        done     = 1'b0;
        repeat (2) step();

        // Long stall at sample 37
        rdy_mode = 2;
        m_ready  = 1'b1;
        done     = 1'b1;
        wait_sample(37, 100);
        m_ready = 1'b0;
        nrd     = 0;
        repeat (20) begin
            step();
            if (rd) nrd++;
        end
        chk("stall_no_rd", 32'(nrd), 32'd0);
        chk("stall_hold", 32'({m_valid, m_data}), 32'({1'b1, 16'd37}));
        m_ready  = 1'b1;
        rdy_mode = 0;
        wait_fd(400);
        chk("stall_span", 32'(t_last - t_first), 32'd275);
        done = 1'b0;
        repeat (2) step();

        // Overrun mid-frame, then restart on the frame_done cycle
        ov0  = ov_seen;
        done = 1'b1;
        wait_sample(100, 200);
        done = 1'b0;
        step();
        done = 1'b1;
        wait_sample(200, 200);
        done = 1'b0;
        wait_fd(300);
        done = 1'b1;
        step();
        chk("restart_rd", 32'({busy, rd, addr}), 32'({1'b1, 1'b1, 6'd0}));
        step();
        chk("ovr_count", 32'(ov_seen - ov0), 32'd1);
        wait_fd(400);
        done = 1'b0;
        repeat (2) step();

        // Asynchronous reset mid-frame
        done = 1'b1;
        wait_sample(150, 300);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({addr, rd, m_data, m_valid, m_last, busy, frame_done, overrun}), 32'd0);
        done = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        done = 1'b1;
        wait_fd(400);
        chk("post_reset_span", 32'(t_last - t_first), 32'd255);
        done = 1'b0;
        repeat (2) step();

        // done held high: one frame only
        fd0  = fd_seen;
        ov0  = ov_seen;
        done = 1'b1;
        repeat (600) step();
        done = 1'b0;
        step();
        chk("hold_frames", 32'(fd_seen - fd0), 32'd1);
        chk("hold_no_overrun", 32'(ov_seen - ov0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rfft_unloader.md
Name: rfft_unloader

Overview:
- Downstream stage of the 256-point real FFT core (Q8.8, 4 lanes x 64 addresses).
- After the core asserts done, it walks Addr 0..63 and captures Dout0..Dout3 for each address.
- It serialises the 256 results into a one-sample-per-beat valid/ready stream for the next stage (magnitude, packetiser).
- A two-slot lane buffer sustains 1 sample/cycle under no backpressure.

Parameters:
- WIDTH, 16, sample width (Q8.8 two's complement).
- LANES, 4, samples per core address (fixed 4; Dout0..Dout3).
- DEPTH, 64, core addresses per frame.
- ADDR_W, 6, width of Addr (log2 DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- done  in  1  core completion level; a frame starts on its rising edge.
- Addr  out  ADDR_W  core read address.
- Rd  out  1  core read strobe; Dout0..3 valid exactly 1 cycle after Rd=1.
- Dout0  in  WIDTH  core lane 0 data.
- Dout1  in  WIDTH  core lane 1 data.
- Dout2  in  WIDTH  core lane 2 data.
- Dout3  in  WIDTH  core lane 3 data.
- m_data  out  WIDTH  stream sample.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with sample 255 of the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last handshake.
- overrun  out  1  one-cycle pulse when a done edge is dropped.

Behaviour:
- Reset (async, all registers) to 0: Addr, Rd, m_data, m_valid, m_last, busy, frame_done, overrun, internal done_q, state=IDLE.
- Edge detect: start = done & ~done_q, with done_q registered. A level held high does not retrigger.
- States:
  - IDLE: start -> RUN and busy=1.
  - RUN: issue reads and stream. After the handshake of sample 255 -> IDLE with busy=0; frame_done=1 on the next cycle.
- Read issue, Rd=1 with Addr=n, occurs only when:
  - n<DEPTH, and
  - (free slots - reads in flight) >= 1, counting a slot freed by this cycle's lane-3 handshake as free.
  - Addr increments by 1 after each read. It never wraps; it holds 63 after the last read and returns to 0 at the next start.
- Capture: on the cycle after Rd=1, Dout0..3 are written into the next slot in ping-pong order. Slot sample order is lane 0,1,2,3, giving sample index 4*addr+lane.
- Stream rules:
  - m_valid/m_data/m_last stay stable while m_valid=1 and m_ready=0.
  - A handshake is m_valid & m_ready.
  - After the handshake of lane 3, the slot is freed and the next slot is presented on the next cycle if it is filled.
  - m_valid never depends combinationally on m_ready.
- Latency: start sampled at edge E0 -> first Rd/Addr=0 in cycle after E0 -> m_valid=1 with sample 0 two cycles after E0.
- Throughput: with m_ready=1, the stream is 256 consecutive valid cycles with no bubbles and 64 Rd pulses total.
- m_last is 1 only while sample 255 is presented.
- overrun:
  - Any start while busy=1 pulses overrun and is ignored; this includes the cycle of the final handshake.
  - A start in the cycle frame_done=1 (state IDLE) is accepted.
- Reset mid-frame discards all buffered data, drops in-flight reads and returns to IDLE. No partial-frame resume.
- Width: data passes through unmodified; no rounding or saturation.

Test Plan:
- Continuous: model returns Dout_k = 4*addr+k, m_ready=1, done 0->1 -> m_data 0,1,...,255 on consecutive cycles starting 2 cycles after the edge. m_last on 255, frame_done one cycle later, exactly 64 Rd pulses, Addr 0..63 in order.
- Backpressure: m_ready alternating 1,0,1,0 -> each of 0..255 delivered exactly once, in order. m_data unchanged across every stalled cycle.
- Long stall: m_ready=0 for 20 cycles at sample 37 -> no Rd while both slots are full, at most 2 groups buffered. Resume yields 37,38,... with no loss or duplicates.
- Overrun: pulse done low then high at sample 100 -> overrun=1 for one cycle; the frame still completes 0..255. A second start in the frame_done cycle launches a new frame at Addr 0.
- Reset mid-frame: Reset_n low at sample 150 -> all outputs 0 immediately (asynchronously). Release, then a done edge -> fresh frame from sample 0.
- Level hold: done held high for 600 cycles -> exactly one frame, no overrun.
